// File: rtl/bus_arb_pkg.sv
// Shared definitions for the 16-requester round-robin word-path arbiter.
//   N_REQ       : number of requesters sharing the 32-bit word path
//   SEL_W       : width of the mux select / granted index
//   arb_state_t : arbiter FSM state (IDLE waits for a request, GRANT serves one)
//   onehot16    : index -> one-hot requester vector
package bus_arb_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Rotating-priority picker: returns the first set request bit at index
// ptr, ptr+1, ... wrapping modulo 16.
//   req   [15:0] in  : request vector
//   ptr   [3:0]  in  : highest-priority index this round
//   found        out : at least one request is set
//   idx   [3:0]  out : chosen requester index
module rr_pick16
  import bus_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [SEL_W-1:0]   w_off;
  logic               w_hit;

  // Shifting the doubled vector right by ptr places req[ptr] at bit 0 with
  // the wrapped-around bits following, so the lowest set bit is the winner.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  always_comb begin
    w_off = '0;
    w_hit = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_rot[i] && !w_hit) begin
        w_off = SEL_W'(i);
        w_hit = 1'b1;
      end
    end
  end

  assign found = |req;
  assign idx   = ptr + w_off;

endmodule

// File: rtl/bus_arb16_rr.sv
// Round-robin arbiter sharing one 32-bit word path among 16 requesters.
// sel drives the select of the external 16:1 word mux directly; each
// transferred word is handshaken with the downstream consumer.
//   clk, rst         in  : clock, synchronous active-high reset
//   req       [15:0] in  : requester i has a valid word on mux input i
//   out_ready        in  : consumer accepts the current word
//   sel       [3:0]  out : mux select (holds last granted index in IDLE)
//   gnt       [15:0] out : one-hot grant, zero when not granting
//   out_valid        out : mux output holds a valid word
//   ack       [15:0] out : per-beat pulse on the granted requester
//   busy             out : arbiter is in GRANT
module bus_arb16_rr
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  output logic [N_REQ-1:0] ack,
  output logic             busy
);

  localparam logic [SEL_W-1:0] LAST_BEAT = SEL_W'(MAX_BURST - 1);

  arb_state_t       r_state;
  logic [SEL_W-1:0] r_gnt_idx;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_beat_cnt;

  logic             w_found;
  logic [SEL_W-1:0] w_pick_idx;
  logic             w_beat;
  logic             w_last;

  rr_pick16 u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_pick_idx)
  );

  assign busy      = (r_state == ST_GRANT);
  assign sel       = r_gnt_idx;
  assign gnt       = busy ? onehot16(r_gnt_idx) : '0;
  // Suppressed under reset so a word pending at reset is not consumed.
  assign out_valid = busy & req[r_gnt_idx] & ~rst;
  assign w_beat    = out_valid & out_ready;
  assign ack       = w_beat ? onehot16(r_gnt_idx) : '0;
  assign w_last    = (r_beat_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt_idx  <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt_idx  <= w_pick_idx;
            r_beat_cnt <= '0;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Tenure ends on withdrawal or on the final beat of the burst.
          if (!req[r_gnt_idx] || (w_beat && w_last)) begin
            r_state <= ST_IDLE;
            r_ptr   <= r_gnt_idx + SEL_W'(1);
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + SEL_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb16_rr.sv
module tb_bus_arb16_rr;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        out_ready;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        out_valid;
  logic [15:0] ack;
  logic        busy;

  bus_arb16_rr #(.MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid),
    .ack       (ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        ov;
    logic [15:0] ack;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ack_cnt[16];

  // Reference state
  logic       m_busy = 1'b0;
  logic [3:0] m_idx  = '0;
  logic [3:0] m_ptr  = '0;
  int         m_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 16; i++) ack_cnt[i] = 0;
  endtask

  // Apply one cycle of inputs, queue the expected outputs, advance the model.
  task automatic cyc(input logic r, input logic [15:0] rq, input logic rdy);
    exp_t e;
    logic hit;
    int   j;
    rst = r; req = rq; out_ready = rdy;
    e.sel  = m_idx;
    e.busy = m_busy;
    e.gnt  = m_busy ? (16'h1 << m_idx) : 16'h0;
    e.ov   = m_busy && rq[m_idx] && !r;
    e.ack  = (e.ov && rdy) ? (16'h1 << m_idx) : 16'h0;
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      m_busy = 1'b0; m_idx = '0; m_ptr = '0; m_cnt = 0;
    end else if (!m_busy) begin
      hit = 1'b0;
      for (int k = 0; k < 16; k++) begin
        j = (int'(m_ptr) + k) % 16;
        if (rq[j] && !hit) begin
          hit = 1'b1;
          m_idx = 4'(j);
        end
      end
      if (hit) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (!rq[m_idx]) begin
      m_busy = 1'b0;
      m_ptr  = m_idx + 4'd1;
    end else if (rdy) begin
      if (m_cnt == MAXB - 1) begin
        m_busy = 1'b0;
        m_ptr  = m_idx + 4'd1;
      end else begin
        m_cnt++;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sel", 32'(sel), 32'(e.sel));
      chk("gnt", 32'(gnt), 32'(e.gnt));
      chk("out_valid", 32'(out_valid), 32'(e.ov));
      chk("ack", 32'(ack), 32'(e.ack));
      chk("busy", 32'(busy), 32'(e.busy));
    end
    for (int i = 0; i < 16; i++)
      if (ack[i] === 1'b1) ack_cnt[i]++;
  end

  initial begin
    clr_counts();
    rst = 1'b1; req = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 16'h0, 1'b0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);

    // Single request from index 3, full rate
    clr_counts();
    cyc(1'b0, 16'h0008, 1'b1);
    chk("t1_sel", 32'(sel), 32'd3);
    chk("t1_gnt", 32'(gnt), 32'h0008);
    repeat (4) cyc(1'b0, 16'h0008, 1'b1);
    repeat (2) cyc(1'b0, 16'h0000, 1'b1);
    chk("t1_acks", 32'(ack_cnt[3]), 32'd4);
    chk("t1_idle", 32'(busy), 32'd0);
    // ptr must now be 4: 4 beats 3 in the rotation
    cyc(1'b0, 16'h0018, 1'b1);
    chk("t1_ptr", 32'(sel), 32'd4);
    repeat (4) cyc(1'b0, 16'h0018, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);

    // Fairness between 0 and 15 with wrap
    clr_counts();
    repeat (30) cyc(1'b0, 16'h8001, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("fair0", 32'(ack_cnt[0]), 32'd12);
    chk("fair15", 32'(ack_cnt[15]), 32'd12);

    // Back-pressure on index 5
    clr_counts();
    cyc(1'b0, 16'h0020, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sel", 32'(sel), 32'd5);
      chk("bp_ack", 32'(ack), 32'h0);
      cyc(1'b0, 16'h0020, 1'b0);
    end
    cyc(1'b0, 16'h0020, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("bp_acks", 32'(ack_cnt[5]), 32'd1);

    // Withdraw index 7 after 2 beats
    clr_counts();
    repeat (3) cyc(1'b0, 16'h0080, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("wd_idle", 32'(busy), 32'd0);
    chk("wd_acks", 32'(ack_cnt[7]), 32'd2);
    cyc(1'b0, 16'h0180, 1'b1);
    chk("wd_ptr", 32'(sel), 32'd8);
    cyc(1'b0, 16'h0000, 1'b1);

    // Contending req[2] during tenure of index 9
    clr_counts();
    cyc(1'b0, 16'h0200, 1'b1);
    repeat (4) cyc(1'b0, 16'h0204, 1'b1);
    chk("ct_acks2_early", 32'(ack_cnt[2]), 32'd0);
    repeat (5) cyc(1'b0, 16'h0004, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("ct_acks9", 32'(ack_cnt[9]), 32'd4);
    chk("ct_acks2", 32'(ack_cnt[2]), 32'd4);

    // Reset during beat 2 of index 12
    clr_counts();
    repeat (2) cyc(1'b0, 16'h1000, 1'b1);
    cyc(1'b1, 16'h1000, 1'b1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_gnt", 32'(gnt), 32'h0);
    chk("mr_sel", 32'(sel), 32'd0);
    cyc(1'b0, 16'h1000, 1'b1);
    chk("mr_regrant", 32'(gnt), 32'h1000);
    repeat (4) cyc(1'b0, 16'h1000, 1'b1);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("mr_acks", 32'(ack_cnt[12]), 32'd5);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [15:0] rq;
      rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
      cyc(($urandom_range(0, 39) == 0), rq, 1'($urandom_range(0, 3) != 0));
    end

    @(negedge clk); #1;
    chk("q_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arb16_rr.md
# bus_arb16_rr

Round-robin arbiter that shares one 32-bit word path among 16 requesters. It drives the 4-bit select of the 16-to-1 32-bit word mux and handshakes each transferred word with the downstream consumer. Requester i presents its word on mux input i. The block sits between the peripheral sources and the single shared consumer (display/bus master).

## Interface
- MAX_BURST, 4: maximum beats granted to one requester per tenure (1..16).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  16  req[i]=1: requester i has a valid word on mux input i; held until acked or withdrawn.
- out_ready  in  1  consumer accepts the current word this cycle.
- sel  out  4  mux select = granted index.
- gnt  out  16  one-hot grant; all zero when not granting.
- out_valid  out  1  mux output holds a valid word.
- ack  out  16  one-cycle pulse on gnt bit when a beat transfers; requester advances its word.
- busy  out  1  1 in GRANT state.

## Operation
- States: IDLE, GRANT. Registers: state, gnt_idx[3:0], ptr[3:0], beat_cnt[3:0].
- IDLE: if req != 0, pick the first set bit at index ptr, ptr+1, ... wrapping mod 16; load gnt_idx, clear beat_cnt, go GRANT. If req == 0, stay.
- GRANT: sel = gnt_idx; gnt = one-hot(gnt_idx); out_valid = req[gnt_idx] (combinational).
- Beat = out_valid & out_ready. On a beat: ack[gnt_idx]=1 in the same cycle, beat_cnt++.
- Leave GRANT to IDLE when: a beat occurs with beat_cnt == MAX_BURST-1, or req[gnt_idx]==0 (withdrawn; no ack). On leaving, ptr <= gnt_idx+1 (4-bit wrap, 15 -> 0).
- Requests from non-granted indices are ignored during GRANT; no preemption.
- In IDLE, sel holds the last granted index; gnt=0, out_valid=0, ack=0.
- out_ready while out_valid=0 has no effect.

## Timing
- Reset values: state IDLE, ptr 0, gnt_idx 0, beat_cnt 0; sel 0, gnt 0, out_valid 0, ack 0, busy 0.
- Arbitration latency: req rising at edge t produces gnt/out_valid valid from edge t+1.
- Tenure ends with one IDLE bubble cycle; next grant appears 2 cycles after the last beat's edge.
- Full-rate burst: MAX_BURST beats in MAX_BURST consecutive cycles when out_ready is held high.
- Simultaneous last beat and req drop on the same cycle: the beat counts (acked); tenure ends.
- rst asserted mid-burst: all state returns to reset values at the next edge; no ack issued that cycle; the pending word is not consumed.
- ack and out_valid are combinational from registered state plus req/out_ready; there is no registered output path.

## Structure
- Package bus_arb_pkg: N_REQ=16, SEL_W=4, state encoding (IDLE=1'b0, GRANT=1'b1).
- Sub-module rr_pick16: combinational rotating priority picker (req[15:0], ptr[3:0] -> found, idx[3:0]); implemented as a double-width (32-bit) rotate plus priority encode.
- Top level instantiates bus_arb16_rr alongside the 16:1 32-bit word mux; sel is wired directly to the mux select.

## Test plan
- Reset then single request: req=0x0008, out_ready=1 -> sel=3, gnt=0x0008 one cycle later; ack[3] pulses 4 cycles; then IDLE; ptr=4.
- Round-robin fairness: req=0x8001 held, MAX_BURST=1 -> grants alternate 0, 15, 0, 15, ...; ptr wraps from 0 to 1 and from 15 to 0.
- Back-pressure: grant index 5, out_ready low for 3 cycles -> out_valid=1 and sel=5 steady, ack=0; on out_ready=1, ack[5] pulses exactly once.
- Withdraw mid-burst: grant index 7, 2 beats, then req[7]=0 -> no further ack; next edge IDLE; ptr=8.
- Simultaneous events: last beat and req drop in the same cycle -> ack pulses; IDLE next. Contending req[2] arriving during GRANT for index 9 -> served only after the tenure ends.
- Reset mid-burst: rst=1 during beat 2 of index 12 -> next edge all outputs 0, ptr=0; with req still 0x1000, regrant index 12 one cycle after rst drops.
